// File: rtl/cache_pkg.sv
// Shared types and derived sizes for the cache line mover.
// The derived sizes describe the default line geometry; the mover recomputes
// its own copies from its parameters so that other geometries still work.
package cache_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LINE_BYTES_DEF = 16;

    localparam int WORD_BYTES     = DATA_WIDTH_DEF / 8;
    localparam int WORDS_PER_LINE = LINE_BYTES_DEF / WORD_BYTES;
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES_DEF);
    localparam int WORD_OFF_BITS  = $clog2(WORD_BYTES);
    localparam int LINE_BITS      = LINE_BYTES_DEF * 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } mover_state_e;

    // The aggregate response is the first non-OKAY one seen in a command.
    function automatic axi_resp_e keep_first_err(axi_resp_e cur, logic [1:0] resp);
        return (cur == OKAY) ? axi_resp_e'(resp) : cur;
    endfunction

endpackage

// File: rtl/cache_line_mover.sv
// Moves one cache line between the cache and an AXI4-Lite memory port,
// one word per transaction, with a single transaction outstanding.
module cache_line_mover
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_evict,
    input  logic [ADDR_WIDTH-1:0]   cmd_line_addr,
    input  logic [LINE_BYTES*8-1:0] cmd_wline,
    output logic                    done_valid,
    output logic [LINE_BYTES*8-1:0] done_rline,
    output logic [1:0]              done_resp,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
);

    localparam int WB  = DATA_WIDTH / 8;
    localparam int WPL = LINE_BYTES / WB;
    localparam int BW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [BW-1:0]         LAST      = BW'(WPL - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    mover_state_e              state;
    logic [BW-1:0]             beat;
    logic                      is_evict_q;
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [LINE_BYTES*8-1:0]   wline_q;
    axi_resp_e                 err_q;
    logic                      aw_done, w_done;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic [BW-1:0] beat_nxt;

    assign aw_fire  = m_awvalid && m_awready;
    assign w_fire   = m_wvalid && m_wready;
    assign b_fire   = m_bvalid && m_bready;
    assign ar_fire  = m_arvalid && m_arready;
    assign r_fire   = m_rvalid && m_rready;
    assign beat_nxt = beat + 1'b1;

    // Full-word writes only, unprivileged secure data accesses.
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = '1;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(logic [ADDR_WIDTH-1:0] base,
                                                        logic [BW-1:0] b);
        return base + ADDR_WIDTH'(b) * ADDR_WIDTH'(WB);
    endfunction

    // Command sequencer: one state register, all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            is_evict_q <= 1'b0;
            base_q     <= '0;
            wline_q    <= '0;
            err_q      <= OKAY;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cmd_ready  <= 1'b1;
            done_valid <= 1'b0;
            done_rline <= '0;
            done_resp  <= 2'b00;
            m_awvalid  <= 1'b0;
            m_awaddr   <= '0;
            m_wvalid   <= 1'b0;
            m_wdata    <= '0;
            m_bready   <= 1'b0;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_rready   <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        is_evict_q <= cmd_is_evict;
                        base_q     <= cmd_line_addr & BASE_MASK;
                        wline_q    <= cmd_wline;
                        beat       <= '0;
                        err_q      <= OKAY;
                        if (cmd_is_evict) begin
                            state     <= WR_REQ;
                            m_awvalid <= 1'b1;
                            m_awaddr  <= cmd_line_addr & BASE_MASK;
                            m_wvalid  <= 1'b1;
                            m_wdata   <= cmd_wline[DATA_WIDTH-1:0];
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= RD_REQ;
                            m_arvalid <= 1'b1;
                            m_araddr  <= cmd_line_addr & BASE_MASK;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; move on once both have.
                    if (aw_fire) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state    <= WR_RESP;
                        m_bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_fire) begin
                        m_bready <= 1'b0;
                        err_q    <= keep_first_err(err_q, m_bresp);
                        if (beat == LAST) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                            done_resp  <= keep_first_err(err_q, m_bresp);
                        end else begin
                            beat      <= beat_nxt;
                            state     <= WR_REQ;
                            m_awvalid <= 1'b1;
                            m_awaddr  <= beat_addr(base_q, beat_nxt);
                            m_wvalid  <= 1'b1;
                            m_wdata   <= wline_q[int'(beat_nxt)*DATA_WIDTH +: DATA_WIDTH];
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (ar_fire) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_fire) begin
                        m_rready <= 1'b0;
                        done_rline[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= m_rdata;
                        err_q    <= keep_first_err(err_q, m_rresp);
                        if (beat == LAST) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                            done_resp  <= keep_first_err(err_q, m_rresp);
                        end else begin
                            beat      <= beat_nxt;
                            state     <= RD_REQ;
                            m_arvalid <= 1'b1;
                            m_araddr  <= beat_addr(base_q, beat_nxt);
                        end
                    end
                end
                DONE: begin
                    // is_evict_q is kept for debug visibility of the last command.
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: a reactive AXI4-Lite slave, a line-level
// model of what each command must produce, and a per-cycle compare process.
module tb_cache_line_mover;

    localparam int N  = 4;
    localparam int LB = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready, cmd_is_evict = 1'b0;
    logic [31:0]  cmd_line_addr = '0;
    logic [127:0] cmd_wline = '0;
    logic         done_valid;
    logic [127:0] done_rline;
    logic [1:0]   done_resp;
    logic         m_awvalid, m_awready = 1'b0;
    logic [31:0]  m_awaddr;
    logic [2:0]   m_awprot, m_arprot;
    logic         m_wvalid, m_wready = 1'b0;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_bvalid = 1'b0, m_bready;
    logic [1:0]   m_bresp = 2'b00;
    logic         m_arvalid, m_arready = 1'b0;
    logic [31:0]  m_araddr;
    logic         m_rvalid = 1'b0, m_rready;
    logic [31:0]  m_rdata = '0;
    logic [1:0]   m_rresp = 2'b00;

    always #5 clk = ~clk;

    cache_line_mover dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_evict(cmd_is_evict),
        .cmd_line_addr(cmd_line_addr), .cmd_wline(cmd_wline),
        .done_valid(done_valid), .done_rline(done_rline), .done_resp(done_resp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    int vectors = 0, errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave configuration and observed traffic.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [31:0] rtab [N];
    logic [1:0]  rrtab[N];
    logic [1:0]  btab [N];
    bit          force_b = 0, force_r = 0;
    logic [31:0] aw_seen[$], w_seen[$], ar_seen[$];
    int          b_hs = 0, r_hs = 0, done_cnt = 0;
    bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [31:0] aw_hold_v, w_hold_v, ar_hold_v;
    bit          aw_last = 0, w_last = 0, ar_last = 0, prev_done = 0;

    // Model expectations for the command in flight.
    logic [127:0] model_line = '0;
    logic [127:0] exp_rline = '0;
    logic [1:0]   exp_resp = 2'b00;

    task automatic clear_slave();
        aw_seen.delete(); w_seen.delete(); ar_seen.delete();
        b_hs = 0; r_hs = 0; done_cnt = 0;
    endtask

    // Handshake monitor on the active edge.
    always @(posedge clk) begin
        aw_last = 0; w_last = 0; ar_last = 0;
        if (rst_n) begin
            aw_hold = m_awvalid && !m_awready; aw_hold_v = m_awaddr;
            w_hold  = m_wvalid && !m_wready;   w_hold_v  = m_wdata;
            ar_hold = m_arvalid && !m_arready; ar_hold_v = m_araddr;
            if (m_awvalid && m_awready) begin
                aw_seen.push_back(m_awaddr); aw_last = 1;
                chk("awprot", m_awprot, 3'b000);
            end
            if (m_wvalid && m_wready) begin
                w_seen.push_back(m_wdata); w_last = 1;
                chk("wstrb", m_wstrb, 4'hF);
            end
            if (m_bvalid && m_bready) b_hs++;
            if (m_arvalid && m_arready) begin
                ar_seen.push_back(m_araddr); ar_last = 1;
                chk("arprot", m_arprot, 3'b000);
            end
            if (m_rvalid && m_rready) r_hs++;
        end else begin
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end
    end

    // Reactive slave, driven on the falling edge.
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (m_awvalid) begin m_awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin m_awready = 0; aw_cnt = 0; end
            if (m_wvalid) begin m_wready = (w_cnt >= w_delay); w_cnt++; end
            else begin m_wready = 0; w_cnt = 0; end
            if (m_arvalid) begin m_arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin m_arready = 0; ar_cnt = 0; end
            m_bvalid = force_b || (b_hs < aw_seen.size() && b_hs < w_seen.size());
            m_bresp  = btab[b_hs % N];
            m_rvalid = force_r || (r_hs < ar_seen.size());
            m_rdata  = rtab[r_hs % N];
            m_rresp  = rrtab[r_hs % N];
        end
    end

    // Per-cycle compare against the protocol rules and the line-level model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_hold) begin
                chk("awvalid_held", m_awvalid, 1'b1);
                chk("awaddr_stable", m_awaddr, aw_hold_v);
            end
            if (w_hold) begin
                chk("wvalid_held", m_wvalid, 1'b1);
                chk("wdata_stable", m_wdata, w_hold_v);
            end
            if (ar_hold) begin
                chk("arvalid_held", m_arvalid, 1'b1);
                chk("araddr_stable", m_araddr, ar_hold_v);
            end
            if (aw_last) chk("awvalid_drop", m_awvalid, 1'b0);
            if (w_last)  chk("wvalid_drop", m_wvalid, 1'b0);
            if (ar_last) chk("arvalid_drop", m_arvalid, 1'b0);
            if (m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready)
                chk("busy_cmd_ready", cmd_ready, 1'b0);
            if (m_bready)
                chk("bready_after_aw_w", (aw_seen.size() == b_hs + 1) && (w_seen.size() == b_hs + 1), 1'b1);
            if (m_rready)
                chk("rready_after_ar", ar_seen.size() == r_hs + 1, 1'b1);
            if (done_valid) begin
                done_cnt++;
                chk("done_single", prev_done, 1'b0);
                chk("done_rline", done_rline, exp_rline);
                chk("done_resp", done_resp, exp_resp);
            end
            prev_done = done_valid;
        end else begin
            prev_done = 0;
        end
    end

    // Derive the expected line and aggregate response from the slave tables.
    task automatic set_model(input bit ev);
        exp_resp = 2'b00;
        for (int i = 0; i < N; i++)
            if (exp_resp == 2'b00) exp_resp = ev ? btab[i] : rrtab[i];
        if (!ev)
            for (int i = 0; i < N; i++) model_line[i*32 +: 32] = rtab[i];
        exp_rline = model_line;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done_valid) begin lat = k; break; end
        end
        chk("done_seen", lat > 0, 1'b1);
    endtask

    task automatic run_cmd(input bit ev, input logic [31:0] a, input logic [127:0] wl,
                           input int lat_exp, output logic [1:0] resp_got);
        logic [31:0] base;
        int          lat, k;
        base = a & ~32'(LB - 1);
        set_model(ev);
        @(negedge clk);
        clear_slave();
        cmd_valid = 1; cmd_is_evict = ev; cmd_line_addr = a; cmd_wline = wl;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1 cmd_valid = 0;
        wait_done(lat);
        resp_got = done_resp;
        if (lat_exp > 0) chk("done_latency", lat, lat_exp);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        if (ev) begin
            chk("aw_count", aw_seen.size(), N);
            chk("w_count", w_seen.size(), N);
            chk("ar_none", ar_seen.size(), 0);
            for (int i = 0; i < N && i < aw_seen.size() && i < w_seen.size(); i++) begin
                chk("awaddr_seq", aw_seen[i], base + 32'(4 * i));
                chk("wdata_seq", w_seen[i], wl[i*32 +: 32]);
            end
        end else begin
            chk("ar_count", ar_seen.size(), N);
            chk("aw_none", aw_seen.size(), 0);
            for (int i = 0; i < N && i < ar_seen.size(); i++)
                chk("araddr_seq", ar_seen[i], base + 32'(4 * i));
        end
    endtask

    logic [1:0] rg;
    int         lat2;

    initial begin
        for (int i = 0; i < N; i++) begin
            rtab[i] = 32'hA0 + 32'(i); rrtab[i] = 2'b00; btab[i] = 2'b00;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, done_valid}, 6'b0);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_done_rline", done_rline, 128'h0);
        rst_n = 1;

        // Zero-wait refill at an unaligned address.
        run_cmd(0, 32'h0000_1234, 128'h0, 2 * N + 1, rg);
        chk("refill_line_lit", done_rline, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("refill_resp_lit", rg, 2'b00);
        chk("refill_ar0_lit", ar_seen.size() > 0 ? ar_seen[0] : 32'hX, 32'h1230);
        chk("refill_ar3_lit", ar_seen.size() > 3 ? ar_seen[3] : 32'hX, 32'h123C);

        // Zero-wait evict; the refilled line must be left untouched.
        run_cmd(1, 32'h0000_2000, {32'h44, 32'h33, 32'h22, 32'h11}, 2 * N + 1, rg);
        chk("evict_aw3_lit", aw_seen.size() > 3 ? aw_seen[3] : 32'hX, 32'h200C);
        chk("evict_w3_lit", w_seen.size() > 3 ? w_seen[3] : 32'hX, 32'h44);
        chk("evict_keeps_line", done_rline, 128'h000000A3_000000A2_000000A1_000000A0);

        // Evict with awready late by three cycles, wready immediate.
        aw_delay = 3;
        run_cmd(1, 32'h0000_2A40, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}, 0, rg);
        aw_delay = 0;

        // Evict with the opposite skew and an error on the last beat.
        w_delay = 2; btab[3] = 2'b11;
        run_cmd(1, 32'h0000_0100, {32'h4, 32'h3, 32'h2, 32'h1}, 0, rg);
        chk("evict_err_lit", rg, 2'b11);
        w_delay = 0; btab[3] = 2'b00;

        // Refill with SLVERR then DECERR; all reads still issued.
        rrtab[1] = 2'b10; rrtab[2] = 2'b11;
        for (int i = 0; i < N; i++) rtab[i] = 32'h5500 + 32'(i);
        ar_delay = 1;
        run_cmd(0, 32'h0000_8008, 128'h0, 0, rg);
        chk("refill_err_lit", rg, 2'b10);
        ar_delay = 0; rrtab[1] = 2'b00; rrtab[2] = 2'b00;

        // Reset during beat 2 of an evict.
        @(negedge clk);
        clear_slave();
        cmd_valid = 1; cmd_is_evict = 1; cmd_line_addr = 32'h5000; cmd_wline = {4{32'h77}};
        @(posedge clk); #1 cmd_valid = 0;
        for (int k = 0; k < 100 && b_hs < 2; k++) @(negedge clk);
        chk("rst_mid_reached", b_hs, 2);
        rst_n = 0;
        #1 chk("rst_mid_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, done_valid}, 6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        clear_slave();
        model_line = '0;
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, 0);

        // Stray responses while idle get no ready.
        force_b = 1; force_r = 1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("stray_no_ready", {m_bready, m_rready, done_valid}, 3'b0);
        end
        force_b = 0; force_r = 0;
        @(negedge clk);

        // Back-to-back refills with cmd_valid held high.
        for (int i = 0; i < N; i++) rtab[i] = 32'hB0 + 32'(i);
        set_model(0);
        clear_slave();
        cmd_valid = 1; cmd_is_evict = 0; cmd_line_addr = 32'h3000;
        @(posedge clk); #1 cmd_line_addr = 32'h4010;
        lat2 = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            chk("b2b_busy", cmd_ready, 1'b0);
            if (done_valid) begin lat2 = k; break; end
        end
        chk("b2b_first_done", lat2, 2 * N + 1);
        @(negedge clk);
        chk("b2b_accept", cmd_ready, 1'b1);
        @(posedge clk); #1 cmd_valid = 0;
        wait_done(lat2);
        chk("b2b_second_latency", lat2, 2 * N + 1);
        chk("b2b_ar_count", ar_seen.size(), 2 * N);
        chk("b2b_ar4_lit", ar_seen.size() > 4 ? ar_seen[4] : 32'hX, 32'h4010);
        chk("b2b_line_lit", done_rline, 128'h000000B3_000000B2_000000B1_000000B0);
        repeat (3) @(negedge clk);
        chk("b2b_done_pulses", done_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
